// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N byte-stream requesters.
// Grants are held for a whole frame; bytes are separated by an enable-low gap and guarded by a watchdog.
module uart_tx_arbiter #(
    parameter int N          = 4,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 65000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     REQ,
    input  logic [8*N-1:0]   DATA,
    input  logic [N-1:0]     LAST,
    output logic [N-1:0]     ACK,
    output logic [N-1:0]     GNT,
    output logic [7:0]       TX_Data,
    output logic             TX_En_Sig,
    input  logic             TX_Done_Sig,
    output logic             BUSY,
    output logic             TIMEOUT_ERR
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PTR_W-1:0]   r_ptr;
    logic [PTR_W-1:0]   r_win;
    logic               r_lock;
    logic [WD_W-1:0]    r_wd;
    logic [GAP_W-1:0]   r_gap;

    logic [7:0]         w_byte [N];
    logic [PTR_W-1:0]   w_rr_win;
    logic [N-1:0]       w_rr_oh;
    logic [N-1:0]       w_win_oh;
    logic               w_any_req;
    logic               w_wd_hit;
    logic               w_gap_end;
    logic               w_relaunch;
    logic [N-1:0]       w_ack_n;
    logic [N-1:0]       w_gnt_n;
    logic [7:0]         w_data_n;
    logic               w_en_n;
    logic               w_busy_n;
    logic               w_terr_n;

    // First requesting index after ptr, searching upward with wrap.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [PTR_W-1:0] ptr, input logic [N-1:0] req);
        logic [PTR_W-1:0] pick;
        logic [PTR_W:0]   idx;
        pick = ptr;
        for (int k = N; k >= 1; k--) begin
            idx = {1'b0, ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N)) begin
                idx = idx - (PTR_W+1)'(N);
            end else begin
                idx = idx;
            end
            if (req[idx[PTR_W-1:0]]) begin
                pick = idx[PTR_W-1:0];
            end else begin
                pick = pick;
            end
        end
        return pick;
    endfunction

    // Unpack the flat data bus into per-requester bytes.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_byte[i] = DATA[8*i +: 8];
        end
    end

    assign w_any_req  = |REQ;
    assign w_rr_win   = rr_pick(r_ptr, REQ);
    assign w_rr_oh    = {{(N-1){1'b0}}, 1'b1} << w_rr_win;
    assign w_win_oh   = {{(N-1){1'b0}}, 1'b1} << r_win;
    assign w_wd_hit   = (TIMEOUT != 0) && (r_wd == WD_LAST);
    assign w_gap_end  = (r_gap == GAP_LAST);
    assign w_relaunch = r_lock && REQ[r_win];

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_any_req ? S_SEND : S_IDLE;
            S_SEND:  w_next_state = (TX_Done_Sig || w_wd_hit) ? S_GAP : S_SEND;
            S_GAP: begin
                if (w_gap_end) begin
                    w_next_state = w_relaunch ? S_SEND : S_IDLE;
                end else begin
                    w_next_state = S_GAP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Owner, frame lock, pointer, watchdog and gap counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr  <= PTR_W'(N - 1);
            r_win  <= '0;
            r_lock <= 1'b0;
            r_wd   <= '0;
            r_gap  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wd  <= '0;
                    r_gap <= '0;
                    if (w_any_req) begin
                        r_win  <= w_rr_win;
                        r_lock <= ~LAST[w_rr_win];
                    end
                end
                S_SEND: begin
                    r_gap <= '0;
                    if (!TX_Done_Sig && w_wd_hit) begin
                        r_lock <= 1'b0;
                    end
                    // Saturating count; the abort fires one step before the limit.
                    if (!TX_Done_Sig && !w_wd_hit && (r_wd != WD_MAX)) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_GAP: begin
                    r_wd  <= '0;
                    r_gap <= r_gap + GAP_W'(1);
                    if (w_gap_end) begin
                        r_gap <= '0;
                        if (w_relaunch) begin
                            r_lock <= ~LAST[r_win];
                        end else begin
                            r_lock <= 1'b0;
                            r_ptr  <= r_win;
                        end
                    end
                end
                default: begin
                    r_lock <= 1'b0;
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        w_ack_n  = '0;
        w_terr_n = 1'b0;
        w_gnt_n  = GNT;
        w_data_n = TX_Data;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_gnt_n  = w_rr_oh;
                    w_data_n = w_byte[w_rr_win];
                end else begin
                    w_gnt_n  = '0;
                end
            end
            S_SEND: begin
                if (TX_Done_Sig) begin
                    w_ack_n  = w_win_oh;
                end else if (w_wd_hit) begin
                    w_terr_n = 1'b1;
                end else begin
                    w_ack_n  = '0;
                end
            end
            S_GAP: begin
                if (w_gap_end && w_relaunch) begin
                    w_data_n = w_byte[r_win];
                end else if (w_gap_end) begin
                    w_gnt_n  = '0;
                end else begin
                    w_gnt_n  = GNT;
                end
            end
            default: w_gnt_n = '0;
        endcase
        w_en_n   = (w_next_state == S_SEND);
        w_busy_n = (w_next_state != S_IDLE);
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ACK         <= '0;
            GNT         <= '0;
            TX_Data     <= 8'h00;
            TX_En_Sig   <= 1'b0;
            BUSY        <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            ACK         <= w_ack_n;
            GNT         <= w_gnt_n;
            TX_Data     <= w_data_n;
            TX_En_Sig   <= w_en_n;
            BUSY        <= w_busy_n;
            TIMEOUT_ERR <= w_terr_n;
        end
    end

endmodule
